// File: rtl/led_blink_top.sv
// LED heartbeat: divides the crystal clock to a square wave with a half-period
// of floor(CLOCK_XTAL/2) cycles and drives it onto every LED (active-low).
`timescale 1ns/1ps
module led_blink_top #(
  parameter int CLOCK_XTAL = 27000000,
  parameter int LED_NUM    = 6
) (
  input  logic               clk,
  input  logic               rst,
  output logic [LED_NUM-1:0] leds
);

  // Half-period in clk cycles; for odd crystals the period runs one cycle short.
  localparam int HALF  = CLOCK_XTAL / 2;
  // HALF = 1 still needs a 1-bit counter that simply sits at 0.
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [LED_NUM-1:0] r_leds;
  logic               w_tc;

  assign w_tc = (r_cnt == TERM);

  // Prescaler: counts 0..HALF-1 and wraps to 0 on terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (w_tc) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

  // All LEDs toggle together on terminal count; start dark (all ones).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_leds <= '1;
    else if (w_tc) r_leds <= ~r_leds;
  end

  assign leds = r_leds;

endmodule

// File: tb/tb_led_blink_top.sv
// Bench for led_blink_top: several divisor instances share clk/rst; a model
// predicts LED state from the number of edges since reset release.
`timescale 1ns/1ps
module tb_led_blink_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] l10, l7, l2, ld;
  logic [3:0] l3;

  int checks = 0;
  int errors = 0;
  int n      = 0;  // rising edges seen since the last reset release

  led_blink_top #(.CLOCK_XTAL(10), .LED_NUM(6)) u_x10 (.clk(clk), .rst(rst), .leds(l10));
  led_blink_top #(.CLOCK_XTAL(7),  .LED_NUM(6)) u_x7  (.clk(clk), .rst(rst), .leds(l7));
  led_blink_top #(.CLOCK_XTAL(2),  .LED_NUM(6)) u_x2  (.clk(clk), .rst(rst), .leds(l2));
  led_blink_top #(.CLOCK_XTAL(3),  .LED_NUM(4)) u_x3  (.clk(clk), .rst(rst), .leds(l3));
  led_blink_top u_def (.clk(clk), .rst(rst), .leds(ld));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: after n edges the LEDs have toggled floor(n/half) times from all-dark.
  function automatic logic [31:0] ref_leds(input int edges, input int half, input int w);
    logic [31:0] ones;
    ones = (32'd1 << w) - 32'd1;
    return ((edges / half) % 2 == 1) ? 32'd0 : ones;
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s x10 n=%0d", tag, n), 32'(l10), ref_leds(n, 5, 6));
    chk($sformatf("%s x7 n=%0d",  tag, n), 32'(l7),  ref_leds(n, 3, 6));
    chk($sformatf("%s x2 n=%0d",  tag, n), 32'(l2),  ref_leds(n, 1, 6));
    chk($sformatf("%s x3 n=%0d",  tag, n), 32'(l3),  ref_leds(n, 1, 4));
    chk($sformatf("%s def n=%0d", tag, n), 32'(ld),  ref_leds(n, 13500000, 6));
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_all("run");
  endtask

  // Assert reset at a random point mid-cycle, check it acts at once and holds.
  task automatic do_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    n   = 0;
    #1;
    check_all("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("rst_hold");
  endtask

  // Release between edges (falling edge + 2).
  task automatic release_rst();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int trans;
    logic [5:0] prev;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");

    // 100 edges from release: exact waveform plus transition count on the /10 instance.
    release_rst();
    trans = 0;
    prev  = l10;
    for (int i = 0; i < 100; i++) begin
      step();
      if (l10 != prev) trans++;
      prev = l10;
    end
    chk("trans100 x10", 32'(trans), 32'd20);

    // Reset three edges after LEDs light (edge 5 + 3), then confirm restart timing.
    do_reset();
    release_rst();
    for (int i = 0; i < 8; i++) step();
    do_reset();
    release_rst();
    for (int i = 0; i < 12; i++) step();

    // Randomized run lengths with resets at random phases.
    for (int s = 0; s < 12; s++) begin
      int len;
      len = $urandom_range(1, 60);
      do_reset();
      release_rst();
      for (int i = 0; i < len; i++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
